riscv_seq_ctrl: RTL and testbench

Multi-cycle sequencer for the RV32I core datapath. Fetches each instruction over a request/grant/response instruction-memory handshake and latches it. It classifies the opcode, then steps the datapath through decode, execute and writeback by driving register-file write enable, writeback select and PC update. Sits between the instruction memory port and the register-file/ALU datapath; traps on unsupported encodings and counts retired instructions.

---
 rtl/riscv_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_riscv_seq_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_seq_ctrl.sv
// Multi-cycle RV32I sequencer: fetch, decode, execute, writeback.
// Drives imem handshake, rf write strobe, wb select and PC update.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   run                 allow new fetches (current instr always completes)
//   imem_req/addr       fetch request and address (= pc)
//   imem_gnt            request accepted
//   imem_rvalid/rdata   instruction response
//   ex_busy             datapath still executing, hold EXEC
//   branch_taken        branch result, sampled when EXEC completes
//   next_pc_in          jump/branch target, sampled when EXEC completes
//   pc, ir              current PC and latched instruction
//   ex_en               high in EXEC
//   rf_we               one-cycle rd write strobe in WB
//   wb_sel              0=ALU 1=imm 2=pc+4 3=pc+imm
//   trap                sticky illegal/misaligned flag
//   instret             retired-instruction counter
module riscv_seq_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            ex_busy,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] next_pc_in,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     ir,
  output logic            ex_en,
  output logic            rf_we,
  output logic [1:0]      wb_sel,
  output logic            trap,
  output logic [31:0]     instret
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    C_OP,
    C_OPIMM,
    C_LUI,
    C_AUIPC,
    C_JAL,
    C_JALR,
    C_BRANCH
  } cls_e;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_IMM  = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;
  localparam logic [1:0] WB_PCIM = 2'd3;

  state_e state_q, state_d;

  logic [31:0]     ir_q, ir_d;
  cls_e            cls_q, cls_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            redir_q, redir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instret_q, instret_d;

  logic [4:0] opc;
  logic       dec_ok;
  cls_e       dec_cls;
  logic [1:0] dec_wb;

  logic is_jump;
  logic is_br;
  logic ex_redir;
  logic ex_misal;
  logic fetch_req;

  assign opc = ir_q[6:2];

  always_comb begin
    dec_ok  = 1'b0;
    dec_cls = C_OP;
    dec_wb  = WB_ALU;
    if (ir_q[1:0] == 2'b11) begin
      unique case (1'b1)
        (opc == 5'b01101): begin
          dec_ok  = 1'b1;
          dec_cls = C_LUI;
          dec_wb  = WB_IMM;
        end
        (opc == 5'b00101): begin
          dec_ok  = 1'b1;
          dec_cls = C_AUIPC;
          dec_wb  = WB_PCIM;
        end
        (opc == 5'b11011): begin
          dec_ok  = 1'b1;
          dec_cls = C_JAL;
          dec_wb  = WB_PC4;
        end
        (opc == 5'b11001): begin
          dec_ok  = 1'b1;
          dec_cls = C_JALR;
          dec_wb  = WB_PC4;
        end
        (opc == 5'b11000): begin
          dec_ok  = 1'b1;
          dec_cls = C_BRANCH;
        end
        (opc == 5'b00100): begin
          dec_ok  = 1'b1;
          dec_cls = C_OPIMM;
        end
        (opc == 5'b01100): begin
          dec_ok  = 1'b1;
          dec_cls = C_OP;
        end
        default: ;
      endcase
    end
  end

  assign is_jump  = (cls_q == C_JAL) ||
                    (cls_q == C_JALR);
  assign is_br    = (cls_q == C_BRANCH);
  assign ex_redir = is_jump | (is_br & branch_taken);
  // A redirect to a non-word address cannot be fetched.
  assign ex_misal = ex_redir & (|next_pc_in[1:0]);

  assign fetch_req = run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (fetch_req && imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = dec_ok ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        if (!ex_busy) state_d = ex_misal ? S_TRAP : S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  always_comb begin
    ir_d      = ir_q;
    cls_d     = cls_q;
    wb_sel_d  = wb_sel_q;
    tgt_d     = tgt_q;
    redir_d   = redir_q;
    pc_d      = pc_q;
    instret_d = instret_q;
    unique case (state_q)
      S_WAIT: begin
        if (imem_rvalid) ir_d = imem_rdata;
      end
      S_DECODE: begin
        cls_d    = dec_cls;
        wb_sel_d = dec_wb;
      end
      S_EXEC: begin
        if (!ex_busy) begin
          tgt_d   = next_pc_in;
          redir_d = ex_redir;
        end
      end
      S_WB: begin
        pc_d      = redir_q ? tgt_q
                            : pc_q + XLEN'(4);
        instret_d = instret_q + 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      cls_q     <= C_OP;
      wb_sel_q  <= WB_ALU;
      tgt_q     <= '0;
      redir_q   <= 1'b0;
      pc_q      <= RESET_PC;
      instret_q <= '0;
    end else begin
      ir_q      <= ir_d;
      cls_q     <= cls_d;
      wb_sel_q  <= wb_sel_d;
      tgt_q     <= tgt_d;
      redir_q   <= redir_d;
      pc_q      <= pc_d;
      instret_q <= instret_d;
    end
  end

  // Request is also masked by rst_n so it is low while reset is held.
  always_comb begin
    imem_req = 1'b0;
    ex_en    = 1'b0;
    rf_we    = 1'b0;
    trap     = 1'b0;
    unique case (state_q)
      S_FETCH: imem_req = fetch_req & rst_n;
      S_EXEC:  ex_en    = 1'b1;
      S_WB:    rf_we    = (cls_q != C_BRANCH) &
                          (|ir_q[11:7]);
      S_TRAP:  trap     = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign wb_sel    = wb_sel_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_riscv_seq_ctrl.sv
// Randomized bench for riscv_seq_ctrl with a transaction-level model.
// Expected outputs come from the instruction's class and handshake timing.
module tb_riscv_seq_ctrl;

  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ex_busy;
  logic        branch_taken;
  logic [31:0] next_pc_in;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        ex_en;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        trap;
  logic [31:0] instret;

  always #5 clk = ~clk;

  riscv_seq_ctrl #(
    .XLEN(32),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .run(run),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .ex_busy(ex_busy),
    .branch_taken(branch_taken),
    .next_pc_in(next_pc_in),
    .pc(pc),
    .ir(ir),
    .ex_en(ex_en),
    .rf_we(rf_we),
    .wb_sel(wb_sel),
    .trap(trap),
    .instret(instret)
  );

  int nvec = 0;
  int nmis = 0;

  logic [31:0] m_pc;
  logic [31:0] m_ret;
  logic [31:0] e_ir;
  logic [1:0]  e_ws;
  bit e_req, e_ex, e_we, e_trap;
  bit chk_ir, chk_ws;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("ex_en", 32'(ex_en), 32'(e_ex));
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("trap", 32'(trap), 32'(e_trap));
    chk("instret", instret, m_ret);
    if (chk_ir) chk("ir", ir, e_ir);
    if (chk_ws) chk("wb_sel", 32'(wb_sel), 32'(e_ws));
  endtask

  task automatic cyc();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  // -1 illegal, 0 OP, 1 OP-IMM, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH
  function automatic int op_class(input logic [31:0] w);
    if (w[1:0] != 2'b11) return -1;
    case (w[6:2])
      5'b01100: return 0;
      5'b00100: return 1;
      5'b01101: return 2;
      5'b00101: return 3;
      5'b11011: return 4;
      5'b11001: return 5;
      5'b11000: return 6;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [1:0] wbsel_of(input int c);
    case (c)
      2:       return 2'd1;
      3:       return 2'd3;
      4, 5:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    logic [6:0]  opc [7];
    logic [31:0] w;
    int k;
    opc = '{7'b0110011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011};
    k = int'($urandom_range(0, 9));
    if (k < 7) begin
      w = $urandom;
      w[6:0] = opc[k];
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    end else begin
      do w = $urandom; while (op_class(w) >= 0);
    end
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = $urandom;
    m_pc = RPC;
    m_ret = 32'd0;
    e_req = 1'b0;
    e_ex = 1'b0;
    e_we = 1'b0;
    e_trap = 1'b0;
    e_ir = 32'd0;
    chk_ir = 1'b1;
    e_ws = 2'd0;
    chk_ws = 1'b1;
    cyc();
    rst_n = 1'b1;
    imem_rvalid = 1'b0;
  endtask

  task automatic trap_phase();
    e_trap = 1'b1;
    e_req = 1'b0;
    e_ex = 1'b0;
    e_we = 1'b0;
    chk_ws = 1'b0;
    repeat (3) begin
      imem_gnt = 1'($urandom);
      imem_rvalid = 1'($urandom);
      ex_busy = 1'($urandom);
      cyc();
    end
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    e_req = 1'b0;
    repeat (n) begin
      imem_gnt = 1'($urandom);
      imem_rvalid = 1'($urandom);
      cyc();
    end
  endtask

  task automatic run_instr(input logic [31:0] w,
                           input int gd,
                           input int rdd,
                           input int bz,
                           input logic tk,
                           input logic [31:0] tgt,
                           input bit stale,
                           input bit drop_run,
                           output bit trapped);
    int  c;
    bit  redir;
    c = op_class(w);
    trapped = 1'b0;
    e_ex = 1'b0;
    e_we = 1'b0;
    e_trap = 1'b0;
    // fetch: stale responses here must be ignored
    for (int i = 0; i < gd; i++) begin
      e_req = run;
      imem_gnt = 1'b0;
      imem_rvalid = (stale && i == 0) ? 1'b1
                                      : 1'($urandom);
      imem_rdata = $urandom;
      ex_busy = 1'($urandom);
      cyc();
    end
    e_req = run;
    imem_gnt = 1'b1;
    imem_rvalid = stale ? 1'b1 : 1'($urandom);
    imem_rdata = $urandom;
    cyc();
    imem_gnt = 1'b0;
    if (drop_run) run = 1'b0;
    e_req = 1'b0;
    for (int i = 0; i < rdd; i++) begin
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      imem_gnt = 1'($urandom);
      cyc();
    end
    imem_rvalid = 1'b1;
    imem_rdata = w;
    imem_gnt = 1'b0;
    cyc();
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    e_ir = w;
    chk_ir = 1'b1;
    chk_ws = 1'b0;
    cyc();
    if (c < 0) begin
      trap_phase();
      trapped = 1'b1;
      return;
    end
    e_ex = 1'b1;
    e_ws = wbsel_of(c);
    chk_ws = 1'b1;
    for (int i = 0; i < bz; i++) begin
      ex_busy = 1'b1;
      next_pc_in = $urandom;
      branch_taken = 1'($urandom);
      cyc();
    end
    ex_busy = 1'b0;
    next_pc_in = tgt;
    branch_taken = tk;
    cyc();
    ex_busy = 1'($urandom);
    next_pc_in = $urandom;
    branch_taken = 1'($urandom);
    e_ex = 1'b0;
    redir = (c == 4) || (c == 5) || (c == 6 && tk);
    if (redir && tgt[1:0] != 2'b00) begin
      trap_phase();
      trapped = 1'b1;
      return;
    end
    e_we = (c != 6) && (w[11:7] != 5'd0);
    cyc();
    e_we = 1'b0;
    m_pc = redir ? tgt : m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
  endtask

  initial begin
    bit tr;
    logic [31:0] w, tgt;
    run = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    ex_busy = 1'b0;
    branch_taken = 1'b0;
    next_pc_in = 32'd0;
    do_reset();
    run = 1'b1;

    run_instr(32'h00500093, 0, 0, 0, 1'b0, 32'h0,
              1'b0, 1'b0, tr);
    chk("lit_addi_pc", pc, 32'h4);
    chk("lit_addi_ret", instret, 32'd1);
    run_instr(32'h00000013, 0, 0, 0, 1'b0, 32'h0,
              1'b0, 1'b0, tr);
    chk("lit_nop_pc", pc, 32'h8);
    run_instr(32'h000000EF, 0, 0, 0, 1'b0, 32'h100,
              1'b0, 1'b0, tr);
    chk("lit_jal_pc", pc, 32'h100);
    chk("lit_jal_wbsel", 32'(wb_sel), 32'd2);
    run_instr(32'h00000063, 0, 0, 0, 1'b0, 32'h80,
              1'b0, 1'b0, tr);
    chk("lit_bnt_pc", pc, 32'h104);
    run_instr(32'h00000063, 0, 0, 0, 1'b1, 32'h40,
              1'b0, 1'b0, tr);
    chk("lit_bt_pc", pc, 32'h40);
    run_instr(32'h00500093, 3, 2, 4, 1'b0, 32'h0,
              1'b0, 1'b0, tr);
    chk("lit_dly_pc", pc, 32'h44);
    chk("lit_dly_ret", instret, 32'd6);
    run_instr(32'h000000EF, 0, 0, 0, 1'b0, 32'h102,
              1'b0, 1'b0, tr);
    chk("lit_mis_trap", 32'(trap), 32'd1);
    chk("lit_mis_pc", pc, 32'h44);
    do_reset();
    chk("lit_rst_pc", pc, RPC);
    run_instr(32'h00000003, 0, 0, 0, 1'b0, 32'h0,
              1'b0, 1'b0, tr);
    chk("lit_ill_trap", 32'(trap), 32'd1);
    do_reset();
    run_instr(32'h00500093, 1, 1, 2, 1'b0, 32'h0,
              1'b0, 1'b1, tr);
    chk("lit_run0_ret", instret, 32'd1);
    idle(6);
    run = 1'b1;
    // reset while waiting for the response
    e_req = 1'b1;
    imem_gnt = 1'b1;
    cyc();
    imem_gnt = 1'b0;
    e_req = 1'b0;
    cyc();
    do_reset();
    run_instr(32'h00500093, 2, 1, 0, 1'b0, 32'h0,
              1'b1, 1'b0, tr);
    chk("lit_stale_pc", pc, 32'h4);
    chk("lit_stale_ret", instret, 32'd1);

    for (int i = 0; i < 300; i++) begin
      bit drop;
      w = rand_word();
      tgt = $urandom;
      if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
      drop = ($urandom_range(0, 15) == 0);
      run_instr(w,
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)),
                1'($urandom), tgt, 1'b0, drop, tr);
      if (tr) begin
        do_reset();
        run = 1'b1;
      end else if (drop) begin
        idle(3);
        run = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule
